// File: rtl/pid_sched_pkg.sv
// Shared definitions for the time-multiplexed PID scheduler: FSM state codes,
// the per-channel context record and the enabled-channel search helper.
package pid_sched_pkg;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE   = 3'd0;
  localparam sched_state_t ST_LOAD   = 3'd1;
  localparam sched_state_t ST_SETTLE = 3'd2;
  localparam sched_state_t ST_COMMIT = 3'd3;
  localparam sched_state_t ST_NEXT   = 3'd4;

  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] err_prev;
    logic [31:0] integral;
  } pid_ctx_t;

  // Returns {found, index} of the lowest set bit of mask at or above start.
  function automatic logic [4:0] next_channel(input logic [15:0] mask, input logic [4:0] start);
    logic [4:0] sel;
    sel = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= start)) sel = {1'b1, 4'(i)};
    end
    return sel;
  endfunction

endpackage

// File: rtl/pid_scheduler_ctx_ram.sv
// pid_ctx_ram: register-based per-channel PID context store (result, previous error,
// integral) with one read port, one write port and a bulk clear for skipped channels.
module pid_ctx_ram
  import pid_sched_pkg::*;
#(
  parameter int NUM_MOTORS = 8,
  parameter int CH_W       = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CH_W-1:0]       i_rd_addr,
  output pid_ctx_t              o_rd_data,
  input  logic                  i_wr_en,
  input  logic [CH_W-1:0]       i_wr_addr,
  input  pid_ctx_t              i_wr_data,
  input  logic [NUM_MOTORS-1:0] i_clr_mask
);

  pid_ctx_t r_mem [NUM_MOTORS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MOTORS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (i_clr_mask[i]) r_mem[i] <= '0;
        else if (i_wr_en && (i_wr_addr == CH_W'(i))) r_mem[i] <= i_wr_data;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pid_scheduler.sv
// pid_scheduler: sweeps enabled motor channels through one shared PID core each control tick.
// Optional PID_SCHED_OVERRUN_EN adds overrun_count/overrun for ticks that land mid-sweep.
module pid_scheduler
  import pid_sched_pkg::*;
#(
  parameter int NUM_MOTORS    = 8,
  parameter int PID_LATENCY   = 24,
  parameter int UPDATE_PERIOD = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_MOTORS-1:0]    channel_en,
  input  logic [NUM_MOTORS*32-1:0] Kp_in,
  input  logic [NUM_MOTORS*32-1:0] Ki_in,
  input  logic [NUM_MOTORS*32-1:0] Kd_in,
  input  logic [NUM_MOTORS*32-1:0] state_in,
  input  logic [NUM_MOTORS*32-1:0] setpoint_in,
  output logic [31:0]              pid_Kp,
  output logic [31:0]              pid_Ki,
  output logic [31:0]              pid_Kd,
  output logic [31:0]              pid_state,
  output logic [31:0]              pid_setpoint,
  output logic [31:0]              ctx_result,
  output logic [31:0]              ctx_err_prev,
  output logic [31:0]              ctx_integral,
  input  logic [31:0]              pid_result,
  input  logic [31:0]              pid_err,
  input  logic [31:0]              pid_integral,
  output logic                     pid_update,
  output logic [NUM_MOTORS*32-1:0] result,
  output logic                     busy,
  output logic                     sweep_done
`ifdef PID_SCHED_OVERRUN_EN
  ,
  output logic [15:0]              overrun_count,
  output logic                     overrun
`endif
);

  localparam int CH_W  = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam int CNT_W = $clog2(UPDATE_PERIOD);
  localparam int SET_W = (PID_LATENCY > 1) ? $clog2(PID_LATENCY) : 1;

  sched_state_t          r_state;
  logic [CNT_W-1:0]      r_period_cnt;
  logic [NUM_MOTORS-1:0] r_mask;
  logic [CH_W-1:0]       r_chan;
  logic [SET_W-1:0]      r_settle_cnt;
  logic                  r_sweep_done;
  logic [31:0]           r_op_kp, r_op_ki, r_op_kd, r_op_state, r_op_setpoint;
  pid_ctx_t              r_op_ctx;
  logic [31:0]           r_result [NUM_MOTORS];

  logic [31:0]           w_kp_ch [NUM_MOTORS];
  logic [31:0]           w_ki_ch [NUM_MOTORS];
  logic [31:0]           w_kd_ch [NUM_MOTORS];
  logic [31:0]           w_state_ch [NUM_MOTORS];
  logic [31:0]           w_setpoint_ch [NUM_MOTORS];
  logic                  w_tick, w_sweep_start, w_commit;
  logic [4:0]            w_first, w_next;
  logic [NUM_MOTORS-1:0] w_clr_mask;
  pid_ctx_t              w_ctx_rd, w_ctx_wr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_chan
      assign w_kp_ch[gi]          = Kp_in[32*gi +: 32];
      assign w_ki_ch[gi]          = Ki_in[32*gi +: 32];
      assign w_kd_ch[gi]          = Kd_in[32*gi +: 32];
      assign w_state_ch[gi]       = state_in[32*gi +: 32];
      assign w_setpoint_ch[gi]    = setpoint_in[32*gi +: 32];
      assign result[32*gi +: 32]  = r_result[gi];
    end
  endgenerate

  assign w_tick        = (r_period_cnt == CNT_W'(UPDATE_PERIOD - 1));
  assign w_sweep_start = (r_state == ST_IDLE) && w_tick && enable;
  assign w_commit      = (r_state == ST_COMMIT);
  assign w_first       = next_channel(16'(channel_en), 5'd0);
  assign w_next        = next_channel(16'(r_mask), 5'(r_chan) + 5'd1);
  // Channels seen disabled at sweep start lose their result and context.
  assign w_clr_mask    = w_sweep_start ? ~channel_en : '0;
  assign w_ctx_wr      = '{result: pid_result, err_prev: pid_err, integral: pid_integral};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_period_cnt <= '0;
    else if (w_tick) r_period_cnt <= '0;
    else r_period_cnt <= r_period_cnt + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mask        <= '0;
      r_chan        <= '0;
      r_settle_cnt  <= '0;
      r_sweep_done  <= 1'b0;
      r_op_kp       <= FLOAT_ZERO;
      r_op_ki       <= FLOAT_ZERO;
      r_op_kd       <= FLOAT_ZERO;
      r_op_state    <= FLOAT_ZERO;
      r_op_setpoint <= FLOAT_ZERO;
      r_op_ctx      <= '0;
    end else begin
      r_sweep_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sweep_start) begin
            r_mask <= channel_en;
            if (w_first[4]) begin
              r_chan  <= CH_W'(w_first[3:0]);
              r_state <= ST_LOAD;
            end else begin
              r_sweep_done <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_op_kp       <= w_kp_ch[r_chan];
          r_op_ki       <= w_ki_ch[r_chan];
          r_op_kd       <= w_kd_ch[r_chan];
          r_op_state    <= w_state_ch[r_chan];
          r_op_setpoint <= w_setpoint_ch[r_chan];
          r_op_ctx      <= w_ctx_rd;
          r_settle_cnt  <= SET_W'(PID_LATENCY - 1);
          r_state       <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == '0) r_state <= ST_COMMIT;
          else r_settle_cnt <= r_settle_cnt - SET_W'(1);
        end
        ST_COMMIT: begin
          // The NEXT decision is taken here so the following LOAD starts immediately.
          if (w_next[4]) begin
            r_chan  <= CH_W'(w_next[3:0]);
            r_state <= ST_LOAD;
          end else begin
            r_sweep_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        ST_NEXT: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MOTORS; i++) r_result[i] <= FLOAT_ZERO;
    end else begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (w_clr_mask[i]) r_result[i] <= FLOAT_ZERO;
        else if (w_commit && (r_chan == CH_W'(i))) r_result[i] <= pid_result;
      end
    end
  end

  pid_ctx_ram #(
    .NUM_MOTORS (NUM_MOTORS),
    .CH_W       (CH_W)
  ) u_ctx_ram (
    .clock      (clock),
    .reset      (reset),
    .i_rd_addr  (r_chan),
    .o_rd_data  (w_ctx_rd),
    .i_wr_en    (w_commit),
    .i_wr_addr  (r_chan),
    .i_wr_data  (w_ctx_wr),
    .i_clr_mask (w_clr_mask)
  );

  assign pid_Kp       = r_op_kp;
  assign pid_Ki       = r_op_ki;
  assign pid_Kd       = r_op_kd;
  assign pid_state    = r_op_state;
  assign pid_setpoint = r_op_setpoint;
  assign ctx_result   = r_op_ctx.result;
  assign ctx_err_prev = r_op_ctx.err_prev;
  assign ctx_integral = r_op_ctx.integral;
  assign pid_update   = w_commit;
  assign busy         = (r_state == ST_LOAD) || (r_state == ST_SETTLE) || (r_state == ST_COMMIT);
  assign sweep_done   = r_sweep_done;

`ifdef PID_SCHED_OVERRUN_EN
  logic [15:0] r_overrun_count;
  logic        r_overrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overrun_count <= '0;
      r_overrun       <= 1'b0;
    end else if (w_tick && busy) begin
      if (r_overrun_count != 16'hFFFF) r_overrun_count <= r_overrun_count + 16'd1;
      r_overrun <= 1'b1;
    end
  end

  assign overrun_count = r_overrun_count;
  assign overrun       = r_overrun;
`endif

endmodule

// File: tb/tb_pid_scheduler.sv
// Self-checking bench for pid_scheduler: timeline scoreboard model checked every cycle,
// plus directed scenarios with literal expectations. Define PID_SCHED_OVERRUN_EN for overrun.
module tb_pid_scheduler;

  localparam int NM  = 4;
  localparam int LAT = 3;
  localparam int S   = LAT + 2;
`ifdef PID_SCHED_OVERRUN_EN
  localparam int PER = 15;
`else
  localparam int PER = 40;
`endif

  logic              clock, reset, enable;
  logic [NM-1:0]     channel_en;
  logic [NM*32-1:0]  Kp_in, Ki_in, Kd_in, state_in, setpoint_in;
  logic [31:0]       pid_Kp, pid_Ki, pid_Kd, pid_state, pid_setpoint;
  logic [31:0]       ctx_result, ctx_err_prev, ctx_integral;
  logic [31:0]       pid_result, pid_err, pid_integral;
  logic              pid_update, busy, sweep_done;
  logic [NM*32-1:0]  result;
`ifdef PID_SCHED_OVERRUN_EN
  logic [15:0]       overrun_count;
  logic              overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] itof(input int n);
    int e;
    logic [31:0] m;
    if (n <= 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (n[b]) e = b;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int ftoi(input logic [31:0] f);
    int e;
    logic [23:0] mant;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    mant = {1'b1, f[22:0]};
    return int'(mant >> (23 - e));
  endfunction

  // Core stand-in: result = previous result + 1.0, plus simple traceable context.
  assign pid_result   = itof(ftoi(ctx_result) + 1);
  assign pid_err      = pid_setpoint ^ pid_state;
  assign pid_integral = ctx_integral + pid_Ki;

  pid_scheduler #(
    .NUM_MOTORS(NM), .PID_LATENCY(LAT), .UPDATE_PERIOD(PER)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .channel_en(channel_en),
    .Kp_in(Kp_in), .Ki_in(Ki_in), .Kd_in(Kd_in), .state_in(state_in), .setpoint_in(setpoint_in),
    .pid_Kp(pid_Kp), .pid_Ki(pid_Ki), .pid_Kd(pid_Kd), .pid_state(pid_state),
    .pid_setpoint(pid_setpoint), .ctx_result(ctx_result), .ctx_err_prev(ctx_err_prev),
    .ctx_integral(ctx_integral), .pid_result(pid_result), .pid_err(pid_err),
    .pid_integral(pid_integral), .pid_update(pid_update), .result(result),
    .busy(busy), .sweep_done(sweep_done)
`ifdef PID_SCHED_OVERRUN_EN
    , .overrun_count(overrun_count), .overrun(overrun)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int          cyc, m_t0, m_done, m_ovr;
  bit          m_active;
  int          m_list[$];
  logic [31:0] m_res[NM], m_cr_a[NM], m_ce_a[NM], m_ci_a[NM];
  logic [31:0] m_kp, m_ki, m_kd, m_st, m_sp, m_cr, m_ce, m_ci;
  int          mp_prev, mp_off, mp_k, mp_ch;
  bit          mp_idle;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc = 0; m_active = 0; m_done = -1; m_ovr = 0; m_t0 = 0;
      m_list.delete();
      for (int i = 0; i < NM; i++) begin
        m_res[i] = 0; m_cr_a[i] = 0; m_ce_a[i] = 0; m_ci_a[i] = 0;
      end
      m_kp = 0; m_ki = 0; m_kd = 0; m_st = 0; m_sp = 0; m_cr = 0; m_ce = 0; m_ci = 0;
    end else begin
      mp_prev = cyc;
      cyc++;
      mp_idle = !m_active;
      if (m_active) begin
        mp_off = mp_prev - m_t0 - 1;
        mp_k   = mp_off / S;
        mp_ch  = m_list[mp_k];
        if (mp_off % S == 0) begin
          m_kp = Kp_in[32*mp_ch +: 32];       m_ki = Ki_in[32*mp_ch +: 32];
          m_kd = Kd_in[32*mp_ch +: 32];       m_st = state_in[32*mp_ch +: 32];
          m_sp = setpoint_in[32*mp_ch +: 32];
          m_cr = m_cr_a[mp_ch]; m_ce = m_ce_a[mp_ch]; m_ci = m_ci_a[mp_ch];
        end
        if (mp_off % S == S - 1) begin
          m_res[mp_ch]  = itof(ftoi(m_cr) + 1);
          m_cr_a[mp_ch] = m_res[mp_ch];
          m_ce_a[mp_ch] = m_sp ^ m_st;
          m_ci_a[mp_ch] = m_ci + m_ki;
          if (mp_k == m_list.size() - 1) begin
            m_active = 0;
            m_done   = cyc;
          end
        end
      end
      if (mp_prev % PER == PER - 1) begin
        if (mp_idle && enable) begin
          m_list.delete();
          for (int i = 0; i < NM; i++) begin
            if (channel_en[i]) m_list.push_back(i);
            else begin
              m_res[i] = 0; m_cr_a[i] = 0; m_ce_a[i] = 0; m_ci_a[i] = 0;
            end
          end
          if (m_list.size() == 0) m_done = cyc;
          else begin
            m_active = 1;
            m_t0     = mp_prev;
          end
        end else if (!mp_idle && m_ovr < 65535) begin
          m_ovr++;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("pid_update", {31'd0, pid_update},
          {31'd0, m_active && ((cyc - m_t0 - 1) % S == S - 1)});
      chk("sweep_done", {31'd0, sweep_done}, {31'd0, cyc == m_done});
      chk("pid_Kp", pid_Kp, m_kp);
      chk("pid_Kd", pid_Kd, m_kd);
      chk("pid_state", pid_state, m_st);
      chk("pid_setpoint", pid_setpoint, m_sp);
      chk("ctx_result", ctx_result, m_cr);
      chk("ctx_err_prev", ctx_err_prev, m_ce);
      chk("ctx_integral", ctx_integral, m_ci);
      for (int i = 0; i < NM; i++) chk("result", result[32*i +: 32], m_res[i]);
`ifdef PID_SCHED_OVERRUN_EN
      chk("overrun_count", {16'd0, overrun_count}, 32'(m_ovr));
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr != 0});
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  int q_upd[$];
  int done_off, busy_cnt;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_tick();
    bit found;
    found = 0;
    for (int i = 0; i < 2 * PER && !found; i++) begin
      @(posedge clock); #1;
      if (!reset && (cyc % PER == PER - 1)) found = 1;
    end
    chk_int("tick_seen", int'(found), 1);
  endtask

  task automatic observe(input int n, input int drop_at);
    q_upd.delete();
    done_off = -1;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (pid_update) q_upd.push_back(i);
      if (sweep_done && done_off < 0) done_off = i;
      if (busy) busy_cnt++;
      if (i == drop_at) enable = 1'b0;
    end
    $display("sweep: updates=%0d done_at=%0d busy_cycles=%0d", q_upd.size(), done_off, busy_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    @(posedge clock); #3;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; channel_en = '0;
    for (int i = 0; i < NM; i++) begin
      Kp_in[32*i +: 32]       = 32'h3F00_0000 + 32'(i);
      Ki_in[32*i +: 32]       = 32'h0000_0100 * 32'(i + 1);
      Kd_in[32*i +: 32]       = 32'h3E00_0000 + 32'(i);
      state_in[32*i +: 32]    = 32'h4000_0000 + 32'(i);
      setpoint_in[32*i +: 32] = 32'h4100_0000 + 32'(i);
    end
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_result", result[31:0], 32'd0);
    chk("reset_pid_Kp", pid_Kp, 32'd0);
    do_reset();
    enable = 1'b1; channel_en = 4'hF;

`ifdef PID_SCHED_OVERRUN_EN
    // Sweep takes 20 cycles with a 15-cycle tick: every other tick overlaps a sweep.
    while (cyc < 20) step(1);
    chk("ovr_count_c20", {16'd0, overrun_count}, 32'd0);
    while (cyc < 35) step(1);
    chk("ovr_count_c35", {16'd0, overrun_count}, 32'd1);
    chk("ovr_flag_c35", {31'd0, overrun}, 32'd1);
    while (cyc < 70) step(1);
    chk("ovr_count_c70", {16'd0, overrun_count}, 32'd2);
    $display("overrun: count=%0d flag=%0d", overrun_count, overrun);
`else
    // All channels enabled.
    wait_tick();
    observe(26, -1);
    chk_int("s1_upd_count", q_upd.size(), 4);
    for (int k = 0; k < 4; k++)
      chk_int("s1_upd_offset", (q_upd.size() > k) ? q_upd[k] : -1, 5 * (k + 1));
    chk_int("s1_done_offset", done_off, 21);
    for (int i = 0; i < NM; i++) chk("s1_result", result[32*i +: 32], 32'h3F80_0000);
    wait_tick();
    observe(26, -1);
    for (int i = 0; i < NM; i++) chk("s1b_result", result[32*i +: 32], 32'h4000_0000);

    // Sparse mask.
    channel_en = 4'b1010;
    wait_tick();
    observe(26, -1);
    chk_int("s2_upd_count", q_upd.size(), 2);
    chk("s2_result0", result[31:0], 32'h0);
    chk("s2_result1", result[63:32], 32'h4040_0000);
    chk("s2_result2", result[95:64], 32'h0);
    chk("s2_result3", result[127:96], 32'h4040_0000);

    // Input change during SETTLE must not reach the core.
    channel_en = 4'hF;
    state_in[31:0] = 32'h4120_0000;
    wait_tick();
    step(2);
    state_in[31:0] = 32'hC120_0000;
    step(3);
    chk("s3_update", {31'd0, pid_update}, 32'd1);
    chk("s3_pid_state", pid_state, 32'h4120_0000);
    step(20);

    // enable drops mid-sweep.
    wait_tick();
    observe(26, 7);
    chk_int("s4_upd_count", q_upd.size(), 4);
    observe(40, -1);
    chk_int("s4_no_sweep_upd", q_upd.size(), 0);
    chk_int("s4_no_sweep_busy", busy_cnt, 0);

    // Reset during SETTLE of channel 2.
    enable = 1'b1;
    wait_tick();
    step(12);
    chk("s5_pre_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("s5_rst_busy", {31'd0, busy}, 32'd0);
    chk("s5_rst_update", {31'd0, pid_update}, 32'd0);
    chk("s5_rst_result", result[31:0], 32'd0);
    chk("s5_rst_result3", result[127:96], 32'd0);
    chk("s5_rst_pid_state", pid_state, 32'd0);
    @(posedge clock); #3;
    reset = 1'b0;
    begin
      int n;
      n = 0;
      for (int i = 1; i <= 60 && n == 0; i++) begin
        @(posedge clock); #1;
        if (busy) n = i;
      end
      chk_int("s5_first_load", n, 40);
    end
    observe(26, -1);
    for (int i = 0; i < NM; i++) chk("s5_result", result[32*i +: 32], 32'h3F80_0000);
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_scheduler.md
# pid_scheduler

Time-multiplexes one context-switchable single-precision PID core across `NUM_MOTORS` motor channels. On every control tick it sweeps the enabled channels in ascending index order. For each channel it presents that channel's gains, state, setpoint and saved context to the core, waits out the core's pipeline latency, pulses the core's update, then stores the result and the new context back. It sits between the per-motor register file (Avalon-facing) and the shared PID datapath, replacing one PID instance per motor.

## Interface
Parameters:
- `NUM_MOTORS`, 8: number of channels, 1..16.
- `PID_LATENCY`, 24: clock cycles from stable operands to valid core outputs; must be ≥1.
- `UPDATE_PERIOD`, 50000: clock cycles per control tick; must be > `NUM_MOTORS*(PID_LATENCY+2)+1`.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: global run; low = no new sweeps.
- `channel_en` in `NUM_MOTORS`: per-channel enable mask, sampled at sweep start.
- `Kp_in`, `Ki_in`, `Kd_in` in `NUM_MOTORS*32`: flattened float gains; channel i occupies bits [32i+31:32i].
- `state_in`, `setpoint_in` in `NUM_MOTORS*32`: flattened float state and setpoint.
- `pid_Kp`, `pid_Ki`, `pid_Kd`, `pid_state`, `pid_setpoint` out 32: operands to the core.
- `ctx_result`, `ctx_err_prev`, `ctx_integral` out 32: saved context of the current channel, to the core.
- `pid_result`, `pid_err`, `pid_integral` in 32: core outputs and next context.
- `pid_update` out 1: one-cycle commit strobe to the core.
- `result` out `NUM_MOTORS*32`: flattened float result per channel.
- `busy` out 1: sweep in progress.
- `sweep_done` out 1: one-cycle pulse at the end of a sweep.

## Operation
- The period counter counts 0..`UPDATE_PERIOD`-1, wraps, and free-runs regardless of `enable`. The tick occurs when the count is `UPDATE_PERIOD`-1.
- FSM states: IDLE, LOAD, SETTLE, COMMIT, NEXT.
- IDLE:
  - On tick with `enable`=1: latch `channel_en` into an internal mask, set channel index = first enabled channel, then go to LOAD.
  - If the mask is all zero: pulse `sweep_done`, stay in IDLE.
- LOAD (1 cycle):
  - Snapshot the channel's Kp/Ki/Kd/state/setpoint and saved context into operand registers that drive the `pid_*`/`ctx_*` outputs.
  - Later changes on the inputs do not affect this channel.
- SETTLE: hold the operands for `PID_LATENCY` cycles using a down-counter.
- COMMIT (1 cycle):
  - `pid_update`=1.
  - Write `pid_result` to `result[i]`, and `pid_result`/`pid_err`/`pid_integral` to the context RAM for channel i.
- NEXT:
  - Advance to the next set bit of the mask with index greater than i, then go to LOAD.
  - If none remains: pulse `sweep_done`, go to IDLE.
  - NEXT is merged into COMMIT's transition and costs no extra cycle.
- Disabled channels are skipped: `result[i]` is forced to 0 and the context is zeroed at the sweep in which they are seen disabled.
- Tick while not IDLE is ignored; the sweep in progress completes unaffected.
- `enable` falling mid-sweep: the sweep completes, then the FSM stays in IDLE.
- Context and results hold floats verbatim; the scheduler does no arithmetic on them.

## Timing
- Reset values: all `result`, context and operand registers 0; `pid_update`=0, `busy`=0, `sweep_done`=0; FSM in IDLE; period counter 0.
- Reset mid-sweep aborts immediately and no COMMIT occurs.
- Per channel: `PID_LATENCY`+2 cycles from entering LOAD to leaving COMMIT.
- LOAD starts the cycle after the tick.
- `busy` is high from LOAD of the first channel through COMMIT of the last.
- `sweep_done` is asserted the cycle after the last COMMIT.
- `result[i]` updates on the clock edge ending COMMIT and is visible the following cycle.

## Configuration
- `PID_SCHED_OVERRUN_EN` defined:
  - Adds output `overrun_count` (out 16): increments (saturating at 0xFFFF) on each tick that arrives while `busy`=1.
  - Adds output `overrun` (out 1): sticky flag, cleared only by reset.
- Not defined: neither port exists and the ignored ticks go uncounted.

## Structure
- Shared package `pid_sched_pkg`: FSM state enum, and the float-zero constant 32'h0000_0000.
- One sub-module, `pid_ctx_ram`: `NUM_MOTORS`×96-bit context store with a single read port and a single write port, both indexed by channel. It is register-based and resets to 0.
- The flattened-bus channel mux lives in the top level.

## Test plan
All scenarios use `NUM_MOTORS`=4, `PID_LATENCY`=3, `UPDATE_PERIOD`=40, with a core model that returns `pid_result` = `ctx_result` + 1.0.
- All channels enabled, tick: `pid_update` pulses at cycles 5, 10, 15, 20 after the tick; `sweep_done` at cycle 21; every `result[i]`=1.0 (32'h3F80_0000). After a second tick every `result[i`]=2.0.
- `channel_en`=4'b1010: only channels 1 and 3 commit (two `pid_update` pulses); `result[0]` and `result[2]` stay 0.
- Change `state_in[0]` during SETTLE of channel 0: `pid_state` holds the LOAD-time value until COMMIT.
- `enable` dropped at cycle 7 of a sweep: the sweep finishes all 4 channels; no LOAD occurs on the next tick.
- Reset asserted during SETTLE of channel 2: all outputs are 0 immediately; after release, the first sweep starts 40 cycles later.
- With `PID_SCHED_OVERRUN_EN` and `UPDATE_PERIOD` forced to 15 in the bench: `overrun` sets and `overrun_count` increments once per overlapped tick.
